// File: rtl/mini_core_pkg.sv
// Shared types for the mini core data-memory responder: request bundle, FSM states, limits.
package mini_core_pkg;

  typedef struct packed {
    logic [31:0] WrData;
    logic [31:0] Address;
    logic        WrEn;
    logic        RdEn;
    logic [3:0]  ByteEn;
  } t_core2mem_req;

  typedef enum logic {
    DMEM_IDLE = 1'b0,
    DMEM_WAIT = 1'b1
  } t_dmem_state;

  localparam int DMEM_WORDS_DEF = 1024;
  localparam int RD_WAIT_MAX    = 15;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/mini_core_dmem_rsp_if.sv
// Core <-> data-memory bus. AccessFaultQ104H exists only when DMEM_ACCESS_FAULT_EN is defined.
interface mini_core_dmem_rsp_if;
  import mini_core_pkg::*;

  t_core2mem_req Core2DmemReqQ103H;
  logic [31:0]   DMemRdDataQ104H;
  logic          ReadyQ104H;
`ifdef DMEM_ACCESS_FAULT_EN
  logic          AccessFaultQ104H;

  modport master (output Core2DmemReqQ103H,
                  input  DMemRdDataQ104H, ReadyQ104H, AccessFaultQ104H);
  modport slave  (input  Core2DmemReqQ103H,
                  output DMemRdDataQ104H, ReadyQ104H, AccessFaultQ104H);
`else
  modport master (output Core2DmemReqQ103H,
                  input  DMemRdDataQ104H, ReadyQ104H);
  modport slave  (input  Core2DmemReqQ103H,
                  output DMemRdDataQ104H, ReadyQ104H);
`endif

endinterface

// File: rtl/mini_core_dmem_array.sv
// Byte-writable word array with a registered, enabled read port (write-first on collision).
module mini_core_dmem_array
  import mini_core_pkg::*;
#(
  parameter int WORDS = DMEM_WORDS_DEF,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          Clock,
  input  logic          Rst,
  input  logic          wr_en_i,
  input  logic [3:0]    byte_en_i,
  input  logic [AW-1:0] wr_idx_i,
  input  logic [31:0]   wr_data_i,
  input  logic          rd_en_i,
  input  logic          rd_zero_i,
  input  logic [AW-1:0] rd_idx_i,
  output logic [31:0]   rd_data_o
);

  logic [31:0] mem_q [WORDS];
  logic [31:0] rd_data_q;
  logic [31:0] rd_word;

  always_ff @(posedge Clock) begin
    if (wr_en_i) mem_q[wr_idx_i] <= byte_merge(mem_q[wr_idx_i], wr_data_i, byte_en_i);
  end

  always_comb begin
    rd_word = mem_q[rd_idx_i];
    if (wr_en_i && (wr_idx_i == rd_idx_i)) rd_word = byte_merge(rd_word, wr_data_i, byte_en_i);
  end

  // Only the read register is reset; array contents survive reset.
  always_ff @(posedge Clock) begin
    if (Rst)          rd_data_q <= 32'h0;
    else if (rd_en_i) rd_data_q <= rd_zero_i ? 32'h0 : rd_word;
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/mini_core_dmem_rsp.sv
// Data-memory responder: read wait-state FSM, Ready generation, optional range check
// (DMEM_ACCESS_FAULT_EN).
module mini_core_dmem_rsp
  import mini_core_pkg::*;
#(
  parameter int DMEM_WORDS = DMEM_WORDS_DEF,
  parameter int RD_WAIT    = 0
) (
  input  logic                 Clock,
  input  logic                 Rst,
  mini_core_dmem_rsp_if.slave  Bus
);

  localparam int         ADDR_W   = $clog2(DMEM_WORDS);
  localparam logic [3:0] CNT_LOAD = (RD_WAIT > 0) ? 4'(RD_WAIT - 1) : 4'd0;

  t_core2mem_req     req;
  t_dmem_state       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              oor_q, oor_d;
  logic [ADDR_W-1:0] idx, rd_idx;
  logic              oor;
  logic              ready, wr_en, rd_en, rd_zero, accept_oor;

  assign req = Bus.Core2DmemReqQ103H;
  assign idx = req.Address[ADDR_W+1:2];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    oor_d      = oor_q;
    ready      = 1'b1;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    rd_zero    = 1'b0;
    rd_idx     = idx;
    accept_oor = 1'b0;
    unique case (state_q)
      DMEM_IDLE: begin
        if (req.WrEn) begin
          wr_en      = !oor;
          accept_oor = oor;
        end else if (req.RdEn) begin
          if (RD_WAIT == 0) begin
            rd_en      = 1'b1;
            rd_zero    = oor;
            accept_oor = oor;
          end else begin
            ready   = 1'b0;
            cnt_d   = CNT_LOAD;
            addr_d  = idx;
            oor_d   = oor;
            state_d = DMEM_WAIT;
          end
        end
      end
      DMEM_WAIT: begin
        // The address latched at acceptance wins over whatever the bus shows now.
        rd_idx = addr_q;
        if (cnt_q == 4'd0) begin
          rd_en      = 1'b1;
          rd_zero    = oor_q;
          accept_oor = oor_q;
          state_d    = DMEM_IDLE;
        end else begin
          ready = 1'b0;
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = DMEM_IDLE;
    endcase
    if (Rst) begin
      state_d    = DMEM_IDLE;
      cnt_d      = 4'd0;
      ready      = 1'b1;
      wr_en      = 1'b0;
      rd_en      = 1'b0;
      accept_oor = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Rst) begin
      state_q <= DMEM_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      oor_q   <= oor_d;
    end
  end

  mini_core_dmem_array #(
    .WORDS (DMEM_WORDS),
    .AW    (ADDR_W)
  ) u_array (
    .Clock     (Clock),
    .Rst       (Rst),
    .wr_en_i   (wr_en),
    .byte_en_i (req.ByteEn),
    .wr_idx_i  (idx),
    .wr_data_i (req.WrData),
    .rd_en_i   (rd_en),
    .rd_zero_i (rd_zero),
    .rd_idx_i  (rd_idx),
    .rd_data_o (Bus.DMemRdDataQ104H)
  );

  assign Bus.ReadyQ104H = ready;

`ifdef DMEM_ACCESS_FAULT_EN
  logic fault_q;
  logic unused_addr;

  assign oor         = |req.Address[31:ADDR_W+2];
  assign unused_addr = ^req.Address[1:0];

  always_ff @(posedge Clock) begin
    if (Rst) fault_q <= 1'b0;
    else     fault_q <= accept_oor;
  end

  assign Bus.AccessFaultQ104H = fault_q;
`else
  logic unused_addr;

  assign oor         = 1'b0;
  assign unused_addr = ^{req.Address[31:ADDR_W+2], req.Address[1:0], accept_oor};
`endif

endmodule

// File: tb/tb_mini_core_dmem_rsp.sv
// Directed bench for mini_core_dmem_rsp: RD_WAIT=0 and RD_WAIT=3 instances side by side.
module tb_mini_core_dmem_rsp;
  import mini_core_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  mini_core_dmem_rsp_if if0 ();
  mini_core_dmem_rsp_if if3 ();

  mini_core_dmem_rsp #(.DMEM_WORDS(1024), .RD_WAIT(0)) u0 (.Clock(clk), .Rst(rst), .Bus(if0));
  mini_core_dmem_rsp #(.DMEM_WORDS(1024), .RD_WAIT(3)) u3 (.Clock(clk), .Rst(rst), .Bus(if3));

  function automatic t_core2mem_req mk(input logic we, input logic re, input logic [3:0] be,
                                       input logic [31:0] addr, input logic [31:0] data);
    t_core2mem_req r;
    r.WrData  = data;
    r.Address = addr;
    r.WrEn    = we;
    r.RdEn    = re;
    r.ByteEn  = be;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  localparam t_core2mem_req IDLE_REQ = '0;

  initial begin
    if0.Core2DmemReqQ103H = IDLE_REQ;
    if3.Core2DmemReqQ103H = IDLE_REQ;
    tick(); tick();
    mid();
    chk("rst_ready0", 32'(if0.ReadyQ104H), 32'd1);
    chk("rst_data0",  if0.DMemRdDataQ104H, 32'h0);
    chk("rst_ready3", 32'(if3.ReadyQ104H), 32'd1);
    chk("rst_data3",  if3.DMemRdDataQ104H, 32'h0);

    // full-word write, then read back with no stall
    tick(); rst = 1'b0;
    if0.Core2DmemReqQ103H = mk(1'b1, 1'b0, 4'hF, 32'h10, 32'h11223344);
    if3.Core2DmemReqQ103H = mk(1'b1, 1'b0, 4'hF, 32'h10, 32'h11223344);
    mid();
    chk("wr_ready0", 32'(if0.ReadyQ104H), 32'd1);
    chk("wr_ready3", 32'(if3.ReadyQ104H), 32'd1);
    tick();
    if0.Core2DmemReqQ103H = mk(1'b0, 1'b1, 4'h0, 32'h10, 32'h0);
    if3.Core2DmemReqQ103H = mk(1'b1, 1'b0, 4'hF, 32'h20, 32'hCAFEF00D);
    mid();
    chk("rd_ready0", 32'(if0.ReadyQ104H), 32'd1);
    chk("wr2_ready3", 32'(if3.ReadyQ104H), 32'd1);
    tick();
    if0.Core2DmemReqQ103H = IDLE_REQ;
    if3.Core2DmemReqQ103H = IDLE_REQ;
    mid();
    chk("rd_data0", if0.DMemRdDataQ104H, 32'h11223344);

    // byte lanes 0 and 2 only
    tick(); if0.Core2DmemReqQ103H = mk(1'b1, 1'b0, 4'b0101, 32'h10, 32'hAABBCCDD);
    tick(); if0.Core2DmemReqQ103H = mk(1'b0, 1'b1, 4'h0, 32'h10, 32'h0);
    tick(); if0.Core2DmemReqQ103H = IDLE_REQ;
    mid();
    chk("byte_lanes", if0.DMemRdDataQ104H, 32'h11BB33DD);

    // write+read together acts as a write; read data holds
    tick(); if0.Core2DmemReqQ103H = mk(1'b1, 1'b1, 4'hF, 32'h20, 32'hDEADBEEF);
    mid();
    chk("wrrd_ready", 32'(if0.ReadyQ104H), 32'd1);
    tick(); if0.Core2DmemReqQ103H = IDLE_REQ;
    mid();
    chk("wrrd_hold", if0.DMemRdDataQ104H, 32'h11BB33DD);
    tick(); if0.Core2DmemReqQ103H = mk(1'b0, 1'b1, 4'h0, 32'h20, 32'h0);
    tick(); if0.Core2DmemReqQ103H = IDLE_REQ;
    mid();
    chk("wrrd_written", if0.DMemRdDataQ104H, 32'hDEADBEEF);

    // RD_WAIT=3 read with a request change mid-stall
    tick(); if3.Core2DmemReqQ103H = mk(1'b0, 1'b1, 4'h0, 32'h10, 32'h0);
    mid();
    chk("w3_ready_t0", 32'(if3.ReadyQ104H), 32'd0);
    chk("w3_data_t0",  if3.DMemRdDataQ104H, 32'h0);
    tick(); if3.Core2DmemReqQ103H = mk(1'b0, 1'b1, 4'h0, 32'h20, 32'h0);
    mid();
    chk("w3_ready_t1", 32'(if3.ReadyQ104H), 32'd0);
    tick(); mid();
    chk("w3_ready_t2", 32'(if3.ReadyQ104H), 32'd0);
    tick(); mid();
    chk("w3_ready_t3", 32'(if3.ReadyQ104H), 32'd1);
    chk("w3_data_t3",  if3.DMemRdDataQ104H, 32'h0);
    tick(); if3.Core2DmemReqQ103H = IDLE_REQ;
    mid();
    chk("w3_data_t4", if3.DMemRdDataQ104H, 32'h11223344);

    // reset in the middle of a stalled read
    tick(); if3.Core2DmemReqQ103H = mk(1'b0, 1'b1, 4'h0, 32'h20, 32'h0);
    mid();
    chk("rw_ready_t0", 32'(if3.ReadyQ104H), 32'd0);
    tick(); rst = 1'b1;
    mid();
    chk("rw_ready_rst", 32'(if3.ReadyQ104H), 32'd1);
    chk("rw_data_rst",  if3.DMemRdDataQ104H, 32'h11223344);
    tick(); rst = 1'b0; if3.Core2DmemReqQ103H = IDLE_REQ;
    mid();
    chk("rw_ready_after", 32'(if3.ReadyQ104H), 32'd1);
    chk("rw_data_after",  if3.DMemRdDataQ104H, 32'h0);
    chk("rw_state_idle",  32'(u3.state_q), 32'(DMEM_IDLE));
    chk("rw_data0_after", if0.DMemRdDataQ104H, 32'h0);
    tick(); if3.Core2DmemReqQ103H = mk(1'b0, 1'b1, 4'h0, 32'h20, 32'h0);
    mid();
    chk("rr_ready_t0", 32'(if3.ReadyQ104H), 32'd0);
    tick(); mid();
    chk("rr_ready_t1", 32'(if3.ReadyQ104H), 32'd0);
    tick(); mid();
    chk("rr_ready_t2", 32'(if3.ReadyQ104H), 32'd0);
    tick(); mid();
    chk("rr_ready_t3", 32'(if3.ReadyQ104H), 32'd1);
    tick(); if3.Core2DmemReqQ103H = IDLE_REQ;
    mid();
    chk("rr_data", if3.DMemRdDataQ104H, 32'hCAFEF00D);

    // upper address bits: wrap to word 4, or fault when the range check is built in
    tick(); if0.Core2DmemReqQ103H = mk(1'b0, 1'b1, 4'h0, 32'h1010, 32'h0);
    tick(); if0.Core2DmemReqQ103H = IDLE_REQ;
    mid();
`ifdef DMEM_ACCESS_FAULT_EN
    chk("oor_rd_data",  if0.DMemRdDataQ104H, 32'h0);
    chk("oor_rd_fault", 32'(if0.AccessFaultQ104H), 32'd1);

    tick(); if0.Core2DmemReqQ103H = mk(1'b1, 1'b0, 4'hF, 32'h0, 32'h12345678);
    mid();
    chk("inr_wr_fault", 32'(if0.AccessFaultQ104H), 32'd0);
    tick(); if0.Core2DmemReqQ103H = mk(1'b1, 1'b0, 4'hF, 32'h1000, 32'h55);
    mid();
    chk("oor_wr_ready", 32'(if0.ReadyQ104H), 32'd1);
    tick(); if0.Core2DmemReqQ103H = IDLE_REQ;
    mid();
    chk("oor_wr_fault1", 32'(if0.AccessFaultQ104H), 32'd1);
    tick(); if0.Core2DmemReqQ103H = mk(1'b0, 1'b1, 4'h0, 32'h0, 32'h0);
    mid();
    chk("oor_wr_fault0", 32'(if0.AccessFaultQ104H), 32'd0);
    tick(); if0.Core2DmemReqQ103H = IDLE_REQ;
    mid();
    chk("oor_wr_word0", if0.DMemRdDataQ104H, 32'h12345678);
`else
    chk("wrap_rd_data", if0.DMemRdDataQ104H, 32'h11BB33DD);
`endif

    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
